ps2_key_sequencer: RTL
======================

# ps2_key_sequencer

Sequences the raw byte stream from `PS2_Controller` (`received_data` / `received_data_en`) into complete key events. It decodes the E0 (extended), F0 (break) and E1 (pause) prefixes and queues make/release events in a small FIFO for the game logic. It also tracks held state of the four arrow keys. It sits between `PS2_Controller` and any consumer that needs whole key events rather than individual bytes.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: event FIFO entries; must be a power of 2, at least 2.
- `CNT_W`, 3: width of `fifo_count`; equals log2(`FIFO_DEPTH`)+1.

Ports:
- `CLOCK_50`  in  1  system clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `received_data`  in  8  byte from `PS2_Controller`.
- `received_data_en`  in  1  one-cycle strobe; `received_data` is valid in that cycle.
- `key_ack`  in  1  pops the FIFO head; ignored when the FIFO is empty.
- `key_ready`  out  1  FIFO non-empty.
- `key_code`  out  8  head event base scancode, with prefixes stripped.
- `key_extended`  out  1  head event was E0-prefixed.
- `key_release`  out  1  head event is a break (1) or a make (0).
- `fifo_count`  out  `CNT_W`  number of queued events.
- `arrow_held`  out  4  {up, down, left, right} held levels.
- `overflow`  out  1  sticky; set when an event is dropped.

## Operation
- Decoder FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP. Only bytes arriving with `received_data_en`=1 are consumed.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> SKIP, with the skip counter loaded to 7.
  - 00, AA, EE, FA, FC, FE, FF -> discarded; FSM stays in IDLE.
  - Any other byte -> push {code, ext=0, rel=0}; FSM stays in IDLE.
- EXT:
  - F0 -> EXT_BRK.
  - 12 -> discarded (fake shift), then IDLE.
  - Any other byte -> push {code, 1, 0}, then IDLE.
- BRK: any byte -> push {code, 0, 1}, then IDLE.
- EXT_BRK:
  - 12 -> discarded, then IDLE.
  - Any other byte -> push {code, 1, 1}, then IDLE.
- SKIP: each strobe decrements the counter; the FSM returns to IDLE when it goes from 1 to 0. This drops the remainder of the 8-byte pause sequence, and no event is produced.
- Arrow tracking uses the extended codes 75=up, 72=down, 6B=left, 74=right. An extended make sets the corresponding bit and an extended break clears it. Tracking is updated at decode, independent of FIFO space.
- FIFO ordering is first in, first out. Outputs show the head entry. `key_code`, `key_extended` and `key_release` are 0 when the FIFO is empty.
- Push when full:
  - Event dropped.
  - `overflow` set until `reset`.
  - Arrow tracking still updated.
- Push and `key_ack` in the same cycle while full: both take effect; count is unchanged and there is no overflow.
- Push and `key_ack` in the same cycle while empty: the push is accepted and the ack is ignored.
- Read/write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset (asynchronous, at any time, including mid-sequence):
  - FSM -> IDLE; skip counter cleared.
  - FIFO emptied.
  - Outputs `key_ready`=0, `key_code`=0, `key_extended`=0, `key_release`=0, `fifo_count`=0, `arrow_held`=0, `overflow`=0.
- The final byte strobe in cycle N produces a registered push; `key_ready` and the head outputs are valid in cycle N+1.
- `arrow_held` updates in cycle N+1.
- `key_ack` sampled in cycle N advances the head in N+1; `fifo_count` is updated in the same cycle.
- Back-to-back strobes on consecutive cycles are accepted; the decoder consumes one byte per cycle.
- `overflow` rises in the cycle after the dropped push.

## Configuration
- `PS2_TYPEMATIC_FILTER_EN` defined:
  - A last-make register holds {code, ext} of the most recent accepted make and is cleared by any break.
  - A make matching that register is discarded, which suppresses keyboard auto-repeat.
  - Arrow tracking is unaffected.
- Not defined: every make is pushed, including typematic repeats.

## Test plan
- Bytes 1C; F0 1C -> two events: {1C,0,0} then {1C,0,1}; `fifo_count` goes 1 then 2.
- Bytes E0 75; E0 F0 75 -> `arrow_held` 1000 after the first pair and 0000 after the second. FIFO holds {75,1,0} and {75,1,1}.
- Bytes E1 14 77 E1 F0 14 F0 77 followed by 29 -> a single event {29,0,0}; the FSM is in IDLE afterwards.
- With `FIFO_DEPTH`=4 and no ack, 5 makes (1C, 32, 21, 23, 24) -> `fifo_count`=4 and `overflow`=1. Draining gives 1C, 32, 21, 23; 24 is lost.
- FIFO full with a simultaneous push and `key_ack` -> `fifo_count` stays 4 and `overflow` stays 0. Assert `reset` after E0 and before the next byte, then send 6B -> event {6B,0,0}.
- Bytes 1C 1C 1C F0 1C -> with `PS2_TYPEMATIC_FILTER_EN` defined: 2 events (make, release). Without it: 4 events.

Source files
------------

// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer
// Turns the PS/2 scancode byte stream into whole make/break key events.
// E0 (extended), F0 (break) and E1 (pause) prefixes are decoded here.
// Decoded events are queued in a small FIFO.
// Held levels of the four extended arrow keys are tracked separately.
// Optional feature: define PS2_TYPEMATIC_FILTER_EN to drop auto-repeat makes.

module ps2_key_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [7:0]       received_data,
    input  logic             received_data_en,
    input  logic             key_ack,
    output logic             key_ready,
    output logic [7:0]       key_code,
    output logic             key_extended,
    output logic             key_release,
    output logic [CNT_W-1:0] fifo_count,
    output logic [3:0]       arrow_held,
    output logic             overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EXT     = 3'd1;
    localparam logic [2:0] ST_BRK     = 3'd2;
    localparam logic [2:0] ST_EXT_BRK = 3'd3;
    localparam logic [2:0] ST_SKIP    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [2:0]       skip_q, skip_d;
    logic [3:0]       arrow_q, arrow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             ovf_q, ovf_d;
    logic [9:0]       mem_q [FIFO_DEPTH];

    logic             push_vld;
    logic             push_ext;
    logic             push_rel;
    logic             event_vld;
    logic             is_ignored;
    logic             pop;
    logic             full;
    logic             wr_en;
    logic [9:0]       head;

    // Keyboard status/ack bytes that never form a key event.
    always_comb begin
        case (received_data)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_ignored = 1'b1;
            default:                                         is_ignored = 1'b0;
        endcase
    end

    // Prefix decoder: one byte per strobe, emits at most one event.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d  = state_q;
        skip_d   = skip_q;
        push_vld = 1'b0;
        push_ext = 1'b0;
        push_rel = 1'b0;
        if (received_data_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (received_data == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (received_data == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (received_data == 8'hE1) begin
                        state_d = ST_SKIP;
                        skip_d  = 3'd7;
                    end else if (!is_ignored) begin
                        push_vld = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (received_data == 8'hF0) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        // E0 12 is a fake shift emitted around extended keys.
                        push_vld = (received_data != 8'h12);
                        push_ext = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    push_vld = 1'b1;
                    push_rel = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    push_vld = (received_data != 8'h12);
                    push_ext = 1'b1;
                    push_rel = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    skip_d  = 3'd0;
                end
            endcase
        end
    end

    // Arrow held levels follow extended make/break, regardless of FIFO space.
    always_comb begin
        arrow_d = arrow_q;
        if (push_vld && push_ext) begin
            case (received_data)
                8'h75:   arrow_d[3] = ~push_rel;
                8'h72:   arrow_d[2] = ~push_rel;
                8'h6B:   arrow_d[1] = ~push_rel;
                8'h74:   arrow_d[0] = ~push_rel;
                default: arrow_d = arrow_q;
            endcase
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       lm_vld_q, lm_vld_d;
    logic [7:0] lm_code_q, lm_code_d;
    logic       lm_ext_q, lm_ext_d;
    logic       lm_match;

    // Auto-repeat filter: a make equal to the last accepted make is dropped.
    always_comb begin
        lm_vld_d  = lm_vld_q;
        lm_code_d = lm_code_q;
        lm_ext_d  = lm_ext_q;
        lm_match  = lm_vld_q && (lm_code_q == received_data) && (lm_ext_q == push_ext);
        event_vld = push_vld;
        if (push_vld) begin
            if (push_rel) begin
                lm_vld_d = 1'b0;
            end else if (lm_match) begin
                event_vld = 1'b0;
            end else begin
                lm_vld_d  = 1'b1;
                lm_code_d = received_data;
                lm_ext_d  = push_ext;
            end
        end
    end

    // Last-make register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            lm_vld_q  <= 1'b0;
            lm_code_q <= 8'h00;
            lm_ext_q  <= 1'b0;
        end else begin
            lm_vld_q  <= lm_vld_d;
            lm_code_q <= lm_code_d;
            lm_ext_q  <= lm_ext_d;
        end
    end
`else
    // Every decoded event goes to the FIFO, typematic repeats included.
    always_comb begin
        event_vld = push_vld;
    end
`endif

    // FIFO control: a pop frees a slot for a push in the same cycle.
    always_comb begin
        pop      = key_ack && (count_q != '0);
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        wr_en    = event_vld && (!full || pop);
        ovf_d    = ovf_q | (event_vld && full && !pop);
        rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control and status state.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q  <= ST_IDLE;
            skip_q   <= 3'd0;
            arrow_q  <= 4'b0000;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            arrow_q  <= arrow_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Event storage: {code, ext, rel} per entry.
    always_ff @(posedge CLOCK_50) begin
        // NOTE: storage is not reset; outputs are masked by the count while empty.
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {received_data, push_ext, push_rel};
        end
    end

    // Head-of-queue outputs, forced to zero when empty.
    always_comb begin
        head         = mem_q[rd_ptr_q];
        key_ready    = (count_q != '0);
        key_code     = key_ready ? head[9:2] : 8'h00;
        key_extended = key_ready & head[1];
        key_release  = key_ready & head[0];
        fifo_count   = count_q;
        arrow_held   = arrow_q;
        overflow     = ovf_q;
    end

endmodule
